gelato_wb_arbiter: RTL

Register-writeback arbiter between the execution units (compute, load/store, tensor) and the register file. Each source pushes writeback packets through a valid/ready handshake into a private 2-entry FIFO. A round-robin arbiter pops at most one packet per cycle into a registered writeback port, which drives the register file write and scoreboard release. No packet is ever dropped; a stalled unit back-pressures only itself.

---
 rtl/gelato_wb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gelato_wb_arbiter.sv
// Register-writeback arbiter: each source feeds a private 2-entry FIFO, and a round-robin
// arbiter drains at most one packet per cycle into a registered writeback port.
module gelato_wb_arbiter #(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned WARP_ID_WIDTH  = 5,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned THREAD_NUM     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned LANE_W = THREAD_NUM * DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rdy,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC*WARP_ID_WIDTH-1:0]    src_warp,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]   src_rd,
  input  logic [NUM_SRC*THREAD_NUM-1:0]       src_mask,
  input  logic [NUM_SRC*LANE_W-1:0]           src_data,
  output logic                                wb_valid,
  output logic [SRC_W-1:0]                    wb_src,
  output logic [WARP_ID_WIDTH-1:0]            wb_warp,
  output logic [REG_ADDR_WIDTH-1:0]           wb_rd,
  output logic [THREAD_NUM-1:0]               wb_mask,
  output logic [LANE_W-1:0]                   wb_data,
  output logic                                busy
);

  logic [1:0]                cnt_q [NUM_SRC];
  logic [NUM_SRC-1:0]        rptr_q;
  logic [NUM_SRC-1:0]        wptr_q;
  logic [SRC_W-1:0]          last_q;

  logic [WARP_ID_WIDTH-1:0]  f_warp_q [NUM_SRC][2];
  logic [REG_ADDR_WIDTH-1:0] f_rd_q   [NUM_SRC][2];
  logic [THREAD_NUM-1:0]     f_mask_q [NUM_SRC][2];
  logic [LANE_W-1:0]         f_data_q [NUM_SRC][2];

  logic                      wb_valid_q;
  logic [SRC_W-1:0]          wb_src_q;
  logic [WARP_ID_WIDTH-1:0]  wb_warp_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic [THREAD_NUM-1:0]     wb_mask_q;
  logic [LANE_W-1:0]         wb_data_q;

  logic                      gnt_vld;
  logic [SRC_W-1:0]          gnt_idx;
  logic [NUM_SRC-1:0]        push;
  logic [NUM_SRC-1:0]        pop;
  int unsigned               cand;

  // Scan starts one past the last grant so every non-empty FIFO is reached within NUM_SRC cycles.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(last_q) + k) % NUM_SRC;
      if (!gnt_vld && (cnt_q[cand] != 2'd0)) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(cand);
      end
    end
  end

  // Ready looks only at the registered count: a full FIFO refuses even while it is being popped.
  always_comb begin
    src_ready = '0;
    push      = '0;
    pop       = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = rdy && (cnt_q[i] != 2'd2);
      push[i]      = src_valid[i] && src_ready[i];
      pop[i]       = rdy && gnt_vld && (32'(gnt_idx) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
      rptr_q     <= '0;
      wptr_q     <= '0;
      last_q     <= SRC_W'(NUM_SRC - 1);
      wb_valid_q <= 1'b0;
      wb_src_q   <= '0;
      wb_warp_q  <= '0;
      wb_rd_q    <= '0;
      wb_mask_q  <= '0;
      wb_data_q  <= '0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i] != pop[i]) begin
          cnt_q[i] <= push[i] ? cnt_q[i] + 2'd1 : cnt_q[i] - 2'd1;
        end
        if (push[i]) wptr_q[i] <= ~wptr_q[i];
        if (pop[i])  rptr_q[i] <= ~rptr_q[i];
      end
      wb_valid_q <= gnt_vld;
      if (gnt_vld) begin
        last_q    <= gnt_idx;
        wb_src_q  <= gnt_idx;
        wb_warp_q <= f_warp_q[gnt_idx][rptr_q[gnt_idx]];
        wb_rd_q   <= f_rd_q[gnt_idx][rptr_q[gnt_idx]];
        wb_mask_q <= f_mask_q[gnt_idx][rptr_q[gnt_idx]];
        wb_data_q <= f_data_q[gnt_idx][rptr_q[gnt_idx]];
      end
    end
  end

  // Payload storage needs no reset; the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        f_warp_q[i][wptr_q[i]] <= src_warp[i*WARP_ID_WIDTH +: WARP_ID_WIDTH];
        f_rd_q[i][wptr_q[i]]   <= src_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        f_mask_q[i][wptr_q[i]] <= src_mask[i*THREAD_NUM +: THREAD_NUM];
        f_data_q[i][wptr_q[i]] <= src_data[i*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    busy = wb_valid_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (cnt_q[i] != 2'd0) busy = 1'b1;
    end
  end

  assign wb_valid = wb_valid_q & rdy;
  assign wb_src   = wb_src_q;
  assign wb_warp  = wb_warp_q;
  assign wb_rd    = wb_rd_q;
  assign wb_mask  = wb_mask_q;
  assign wb_data  = wb_data_q;

endmodule
